poly_reg_sequencer: RTL
=======================

POLY_REG_SEQUENCER -- requirements
Module: poly_reg_sequencer

Interface
REQ-001 SHALL have parameters N = 256 (coefficients per polynomial) and Q = 3329 (Kyber modulus), both taken from the shared package.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  in  1  rising-edge clock shared with the coefficient register array.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 start_load, start_dump  in  1 each  one-cycle command pulses.
REQ-006 s_valid / s_ready / s_data  in / out / in  1 / 1 / 16  input coefficient stream.
REQ-007 m_valid / m_ready / m_data / m_last  out / in / out / out  1 / 1 / 16 / 1  output coefficient stream.
REQ-008 reg_write_enable, reg_read_enable  out  1 each  drive the array's write_enable and read_enable.
REQ-009 reg_i  out  8  array index; reg_data_in  out  16  array data_in; reg_data_out  in  16  array data_out, valid one cycle after a read.
REQ-010 busy  out  1 (high outside IDLE); done  out  1 (one-cycle completion pulse); err  out  1 (sticky range flag).

Function
REQ-011 SHALL have FSM states IDLE, LOAD and DUMP; IDLE->LOAD on start_load; IDLE->DUMP on start_dump; LOAD/DUMP->IDLE after coefficient N-1 completes.
REQ-012 SHALL give start_load priority when both start pulses occur in the same IDLE cycle, and SHALL ignore start pulses outside IDLE.
REQ-013 SHALL hold s_ready=1 only in LOAD; on each s_valid&&s_ready: reg_write_enable=1, reg_i=count, reg_data_in=s_data, all combinational, written at the same edge.
REQ-014 SHALL leave the load count unchanged when s_valid is low, so any number of stall cycles is legal.
REQ-015 SHALL set err when a loaded coefficient is >= Q, still write that coefficient, and clear err only on an accepted start_load.
REQ-016 SHALL, in DUMP, issue reads with reg_read_enable=1 and reg_i=read count, one index per read, in order 0..N-1.
REQ-017 SHALL capture reg_data_out into a 2-entry FIFO in the cycle after each read; m_valid = FIFO non-empty; m_data = FIFO head.
REQ-018 SHALL issue a read only if (FIFO occupancy + reads in flight - pop this cycle) < 2, so data is never lost under backpressure.
REQ-019 SHALL sustain 1 coefficient/cycle with m_ready held high: for a start_dump in cycle t, beats occur in cycles t+3..t+258.
REQ-020 SHALL assert m_last with index N-1 only.
REQ-021 SHALL never assert reg_write_enable and reg_read_enable in the same cycle, and SHALL never issue an index beyond N-1 (no wrap to 0).
REQ-022 SHALL pulse done for one cycle, in the cycle after the final write (LOAD) or after the final m handshake (DUMP), with the state returning to IDLE at that edge.
REQ-023 SHALL hold m_data stable while m_valid=1 and m_ready=0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force: state IDLE, counts 0, FIFO empty, s_ready=0, m_valid=0, m_last=0, reg_write_enable=0, reg_read_enable=0, reg_i=0, reg_data_in=0, busy=0, done=0, err=0.
REQ-025 SHALL abort mid-operation on reset with no further array accesses; array contents are not cleared, and a partial load remains partially written.

Structure
REQ-026 kyber_pkg SHALL hold KYBER_N, KYBER_Q, the coefficient width (16) and the FSM state enum.
REQ-027 the 2-entry output FIFO SHALL be a sub-module named coef_skid_fifo; everything else stays flat.

Verification
REQ-028 load 256 coefficients 0..255 with continuous s_valid -> 256 writes to indices 0..255 in 256 consecutive cycles; done pulses once; err=0.
REQ-029 dump after REQ-028 with m_ready=1 -> m_data 0..255 in cycles t+3..t+258; m_last only on 255; done at t+259.
REQ-030 dump with m_ready toggling 1,0,0,1 -> no lost or duplicated beat, occupancy never > 2, m_data stable while stalled.
REQ-031 load with coefficient 3329 at index 7 -> value written, err=1 until the next start_load; 3328 alone -> err stays 0.
REQ-032 start_load and start_dump in the same cycle -> LOAD entered; start_dump during LOAD -> ignored.
REQ-033 rst_n low at load index 100 -> all outputs zero immediately, no further writes; a following dump returns indices 0..99 as written.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants and types for the polynomial register sequencer.
// Holds N, Q, coefficient/index widths and the sequencer FSM states.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 16;
  localparam int IDX_W   = $clog2(KYBER_N);

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP
  } seq_state_e;

endpackage

// File: rtl/poly_reg_sequencer_if.sv
// Coefficient stream bundle: input stream s_* and output stream m_*.
// slave = sequencer side, master = environment (producer/consumer).
interface poly_reg_sequencer_if;
  import kyber_pkg::*;

  logic  s_valid;
  logic  s_ready;
  coef_t s_data;
  logic  m_valid;
  logic  m_ready;
  coef_t m_data;
  logic  m_last;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/coef_skid_fifo.sv
// Two-entry coefficient FIFO between array read data and m stream.
// Ports: push_i/data_i in, pop_i in, valid_o/data_o head, count_o.
module coef_skid_fifo
  import kyber_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  coef_t      data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output coef_t      data_o,
  output logic [1:0] count_o
);

  coef_t      mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full FIFO is only taken when the head leaves.
  assign do_push = push_i
                && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q
               + {1'b0, do_push}
               - {1'b0, do_pop};
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/poly_reg_sequencer.sv
// Streams a 256-coefficient polynomial into / out of a register array.
// Ports: clk, rst_n, start_load/start_dump pulses, bus (s/m streams),
// reg_* array port (write/read enable, index, data in/out),
// busy (not IDLE), done (completion pulse), err (sticky coef >= Q).
module poly_reg_sequencer
  import kyber_pkg::*;
#(
  parameter int N = KYBER_N,
  parameter int Q = KYBER_Q
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_load,
  input  logic                 start_dump,
  poly_reg_sequencer_if.slave  bus,
  output logic                 reg_write_enable,
  output logic                 reg_read_enable,
  output logic [IDX_W-1:0]     reg_i,
  output coef_t                reg_data_in,
  input  coef_t                reg_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam coef_t            QC    = coef_t'(Q);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   NRD   = (IDX_W + 1)'(N);

  seq_state_e       state_q;
  logic [IDX_W-1:0] ld_cnt_q;
  logic [IDX_W-1:0] out_cnt_q;
  logic [IDX_W:0]   rd_cnt_q;
  logic             inflight_q;
  logic             done_q;
  logic             err_q;

  logic             fifo_valid;
  coef_t            fifo_data;
  logic [1:0]       fifo_cnt;

  logic             wr;
  logic             rd;
  logic             pop;
  logic             last_wr;
  logic             last_beat;
  logic [2:0]       occ_after;

  always_comb begin
    wr        = (state_q == ST_LOAD) && bus.s_valid;
    pop       = fifo_valid && bus.m_ready;
    // Slots already claimed once this cycle's pop is taken out.
    occ_after = {1'b0, fifo_cnt}
              + {2'b0, inflight_q}
              - {2'b0, pop};
    rd        = (state_q == ST_DUMP)
             && (rd_cnt_q < NRD)
             && (occ_after < 3'd2);
    last_wr   = wr && (ld_cnt_q == LAST);
    last_beat = pop && (out_cnt_q == LAST);
  end

  always_comb begin
    reg_i       = '0;
    reg_data_in = '0;
    unique case (1'b1)
      wr: begin
        reg_i       = ld_cnt_q;
        reg_data_in = bus.s_data;
      end
      rd: reg_i = rd_cnt_q[IDX_W-1:0];
      default: ;
    endcase
  end

  assign reg_write_enable = wr;
  assign reg_read_enable  = rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ld_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd;
      unique case (state_q)
        ST_IDLE: begin
          if (start_load) begin
            state_q  <= ST_LOAD;
            ld_cnt_q <= '0;
            err_q    <= 1'b0;
          end else if (start_dump) begin
            state_q   <= ST_DUMP;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          if (wr) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
            if (bus.s_data >= QC) begin
              err_q <= 1'b1;
            end
            if (last_wr) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (rd) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
          if (pop) begin
            out_cnt_q <= out_cnt_q + 1'b1;
          end
          if (last_beat) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the read was issued.
  coef_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (reg_data_out),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  assign bus.s_ready = (state_q == ST_LOAD);
  assign bus.m_valid = fifo_valid;
  assign bus.m_data  = fifo_data;
  assign bus.m_last  = fifo_valid
                    && (out_cnt_q == LAST);

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule
